// File: rtl/irq_ctl.sv
// Fixed-priority interrupt controller: edge-detected sources, pending/mask registers,
// and a request/take/service/EOI handshake. Define IRQ_CTL_SYNC_EN to add a 2-flop input synchronizer.
module irq_ctl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             pc31,
  input  logic             take,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             irq,
  output logic [4:0]       irq_id
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_e;

  state_e           state_q;
  logic             irq_q;
  logic [4:0]       irqId_q;
  logic             causeValid_q;
  logic [4:0]       causeId_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] mask_d;

  logic [N_IRQ-1:0] srcEff;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1cBits;
  logic [N_IRQ-1:0] takeClr;
  logic [N_IRQ-1:0] reqVec;
  logic [4:0]       sel;
  logic             wrPending;
  logic             wrMask;
  logic             eoiWrite;
  logic             takeAccept;
  logic             inflightMaskBit;
  logic             unusedWdata;

`ifdef IRQ_CTL_SYNC_EN
  logic [N_IRQ-1:0] sync1_q;
  logic [N_IRQ-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign srcEff = sync2_q;
`else
  assign srcEff = irq_src;
`endif

  // Only the low N_IRQ bits of write data matter; fold the rest so they count as consumed.
  assign unusedWdata = ^reg_wdata;

  assign wrPending  = reg_we && (reg_addr == ADDR_PENDING);
  assign wrMask     = reg_we && (reg_addr == ADDR_MASK);
  assign eoiWrite   = reg_we && (reg_addr == ADDR_EOI);
  assign takeAccept = (state_q == REQ) && take;

  always_comb begin
    w1cBits         = wrPending ? reg_wdata[N_IRQ-1:0] : '0;
    mask_d          = wrMask ? reg_wdata[N_IRQ-1:0] : mask_q;
    rise            = srcEff & ~prev_q;
    reqVec          = pending_q & mask_q;
    takeClr         = '0;
    inflightMaskBit = 1'b0;
    sel             = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irqId_q == 5'(i)) begin
        takeClr[i]      = takeAccept;
        inflightMaskBit = mask_d[i];
      end
    end
    // Scan downward so the lowest set index (highest priority) is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        sel = 5'(i);
      end
    end
    // A new edge beats a same-cycle software clear or take-clear of that bit.
    pending_d = (pending_q & ~w1cBits & ~takeClr) | rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      prev_q    <= srcEff;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      irqId_q      <= '0;
      causeValid_q <= 1'b0;
      causeId_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((|reqVec) && !pc31) begin
            state_q <= REQ;
            irq_q   <= 1'b1;
            irqId_q <= sel;
          end
        end
        REQ: begin
          // Take beats a kernel-mode entry in the same cycle; the id stays frozen until EOI.
          if (take) begin
            state_q      <= SERV;
            irq_q        <= 1'b0;
            causeValid_q <= 1'b1;
            causeId_q    <= irqId_q;
          end else if (pc31 || !inflightMaskBit) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        SERV: begin
          if (eoiWrite) begin
            state_q      <= IDLE;
            causeValid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_PENDING: reg_rdata[N_IRQ-1:0] = pending_q;
      ADDR_MASK:    reg_rdata[N_IRQ-1:0] = mask_q;
      ADDR_CAUSE:   reg_rdata = {causeValid_q, 26'b0, causeId_q};
      default:      reg_rdata = '0;
    endcase
  end

  assign irq    = irq_q;
  assign irq_id = irqId_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed vector table, hand-written reset/latency sequence,
// and randomized traffic scored against a behavioural model.
module tb_irq_ctl;

  localparam int N = 8;
`ifdef IRQ_CTL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  irq_src;
  logic          pc31;
  logic          take;
  logic          reg_we;
  logic [1:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          irq;
  logic [4:0]    irq_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_ctl #(.N_IRQ(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_src   (irq_src),
    .pc31      (pc31),
    .take      (take),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  typedef struct {
    logic [N-1:0] src;
    logic         pc31;
    logic         take;
    logic         we;
    logic [1:0]   wa;
    logic [31:0]  wd;
    logic         settle;
    logic [1:0]   ra;
    logic [31:0]  expR;
    logic         expIrq;
    logic [4:0]   expId;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [N-1:0] s, logic p, logic t, logic w, logic [1:0] wa,
                              logic [31:0] wd, logic st, logic [1:0] ra, logic [31:0] er,
                              logic ei, logic [4:0] eid);
    vec_t v;
    v.src = s; v.pc31 = p; v.take = t; v.we = w; v.wa = wa; v.wd = wd;
    v.settle = st; v.ra = ra; v.expR = er; v.expIrq = ei; v.expId = eid;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, input logic p, input logic t,
                               input logic w, input logic [1:0] a, input logic [31:0] d);
    irq_src   = s;
    pc31      = p;
    take      = t;
    reg_we    = w;
    reg_addr  = a;
    reg_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
  endtask

  // Behavioural model: interrupt lifecycle phase plus plain bit-vector bookkeeping.
  localparam int PH_IDLE = 0, PH_OFFERED = 1, PH_HANDLING = 2;
  logic [N-1:0] mPrev, mPend, mMask, mS1, mS2;
  int           mPhase;
  int           mId;
  logic         mCv;
  logic [4:0]   mCid;

  function automatic int lowestSet(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mPrev = '0; mPend = '0; mMask = '0; mS1 = '0; mS2 = '0;
    mPhase = PH_IDLE; mId = 0; mCv = 1'b0; mCid = '0;
  endtask

  task automatic modelStep(input logic [N-1:0] s, input logic p, input logic t,
                           input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [N-1:0] seen, newMask, clr;
`ifdef IRQ_CTL_SYNC_EN
    seen = mS2;
    mS2  = mS1;
    mS1  = s;
`else
    seen = s;
`endif
    newMask = (w && a == 2'd1) ? d[N-1:0] : mMask;
    clr     = (w && a == 2'd0) ? d[N-1:0] : '0;
    if (mPhase == PH_IDLE) begin
      if ((mPend & mMask) != '0 && !p) begin
        mId    = lowestSet(mPend & mMask);
        mPhase = PH_OFFERED;
      end
    end else if (mPhase == PH_OFFERED) begin
      if (t) begin
        clr[mId] = 1'b1;
        mCv      = 1'b1;
        mCid     = 5'(mId);
        mPhase   = PH_HANDLING;
      end else if (p || !newMask[mId]) begin
        mPhase = PH_IDLE;
      end
    end else if (w && a == 2'd3) begin
      mPhase = PH_IDLE;
      mCv    = 1'b0;
    end
    mPend = (mPend & ~clr) | (seen & ~mPrev);
    mPrev = seen;
    mMask = newMask;
  endtask

  function automatic logic [31:0] modelRead(logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0] = mPend;
      2'd1: r[N-1:0] = mMask;
      2'd2: r = {mCv, 26'b0, mCid};
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [N-1:0] rs;
    logic         rp, rt, rw;
    logic [1:0]   ra;
    logic [31:0]  rd;

    //            src   pc31  take  we    wa    wd            settle ra    expR          irq   id
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd1, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFF,       1'b0, 2'd1, 32'hFF,       1'b0, 5'd0));
    vecs.push_back(mk(8'h08, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 2'd0, 32'h08,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h08,       1'b1, 5'd3));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd2, 32'h80000003, 1'b0, 5'd3));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 2'd2, 32'h00000003, 1'b0, 5'd3));
    vecs.push_back(mk(8'h24, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 2'd0, 32'h24,       1'b0, 5'd3));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h24,       1'b1, 5'd2));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd2, 32'h80000002, 1'b0, 5'd2));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h20,       1'b0, 5'd2));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 2'd2, 32'h00000002, 1'b0, 5'd2));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h20,       1'b1, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd2, 32'h80000005, 1'b0, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 2'd0, 32'h0,        1'b0, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 2'd1, 32'h0,        1'b0, 5'd5));
    vecs.push_back(mk(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 2'd0, 32'h01,       1'b0, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b0, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'h01,       1'b0, 2'd1, 32'h01,       1'b0, 5'd5));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b1, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 2'd0, 32'h01,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'h01,       1'b0, 2'd1, 32'h01,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b1, 5'd0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h01,       1'b1, 5'd0));
    vecs.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd2, 32'h80000000, 1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 2'd0, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 2'd1, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h10, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10,       1'b1, 2'd0, 32'h10,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        1'b0, 2'd0, 32'h10,       1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10,       1'b0, 2'd0, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, 1'b0, 2'd2, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFFFFFF00, 1'b0, 2'd1, 32'h0,        1'b0, 5'd0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd3, 32'h0,        1'b0, 5'd0));

    doReset();
    reg_addr = 2'd0; #1;
    checkOutput("reset_pending", reg_rdata, 32'h0);
    reg_addr = 2'd2; #1;
    checkOutput("reset_cause", reg_rdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].src, vecs[n].pc31, vecs[n].take, vecs[n].we, vecs[n].wa, vecs[n].wd);
      tick();
      if (vecs[n].settle) begin
        reg_we = 1'b0;
        take   = 1'b0;
        repeat (SYNC_LAT) tick();
      end
      reg_we   = 1'b0;
      take     = 1'b0;
      reg_addr = vecs[n].ra;
      #1;
      checkOutput($sformatf("vec%0d_rdata", n), reg_rdata, vecs[n].expR);
      checkOutput($sformatf("vec%0d_irq", n), {31'b0, irq}, {31'b0, vecs[n].expIrq});
      checkOutput($sformatf("vec%0d_irq_id", n), {27'b0, irq_id}, {27'b0, vecs[n].expId});
    end

    // Source-to-irq latency, then an asynchronous reset while in service.
    doReset();
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFF);
    tick();
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    for (int c = 0; c <= SYNC_LAT; c++) begin
      checkOutput($sformatf("lat_early%0d", c), {31'b0, irq}, 32'h0);
      tick();
    end
    checkOutput("lat_irq", {31'b0, irq}, 32'h1);
    checkOutput("lat_id", {27'b0, irq_id}, 32'd3);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0);
    tick();
    take = 1'b0;
    #1;
    checkOutput("serv_cause", reg_rdata, 32'h80000003);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_cause", reg_rdata, 32'h0);
    reg_addr = 2'd1; #1;
    checkOutput("rst_mask", reg_rdata, 32'h0);
    reg_addr = 2'd0; #1;
    checkOutput("rst_pending", reg_rdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Randomized traffic against the model.
    doReset();
    modelReset();
    for (int it = 0; it < 500; it++) begin
      rs = N'($urandom) & N'($urandom);
      rp = ($urandom_range(0, 7) == 0);
      rt = (mPhase == PH_OFFERED) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rw = ($urandom_range(0, 3) == 0);
      ra = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (ra == 2'd1 && $urandom_range(0, 2) != 0) rd = 32'hFF;
      applyStimulus(rs, rp, rt, rw, ra, rd);
      #1;
      checkOutput("rnd_rdata", reg_rdata, modelRead(ra));
      checkOutput("rnd_irq", {31'b0, irq}, {31'b0, (mPhase == PH_OFFERED)});
      checkOutput("rnd_irq_id", {27'b0, irq_id}, {27'b0, 5'(mId)});
      @(posedge clk);
      modelStep(rs, rp, rt, rw, ra, rd);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
